// File: rtl/nv_ram_rws_pkg.sv
// Shared types and elaboration helpers for the parametrised 1R/1W RAM wrapper.
// The optional post-reset clear sequencer is enabled with NV_RAM_RWS_INIT_CLR_EN.
package nv_ram_rws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_DONE = 2'd2
  } clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int lane_count(input int width, input int lane_w);
    return width / lane_w;
  endfunction

  function automatic bit params_ok(input int depth, input int width,
                                   input int lane_w, input int rd_lat);
    return (depth >= 2) && (lane_w > 0) && ((width % lane_w) == 0) &&
           (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/nv_ram_rws_rd_pipe.sv
// Read path: lane-exact read-during-write merge, 1- or 2-stage data register and
// valid strobe. dout_vld_o pulses for one cycle per read; dout_o holds otherwise.
module nv_ram_rws_rd_pipe #(
  parameter int WIDTH  = 768,
  parameter int LANE_W = 32,
  parameter int RD_LAT = 1,
  parameter int NL     = WIDTH / LANE_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             re_i,
  input  logic             byp_i,
  input  logic [NL-1:0]    wmask_i,
  input  logic [WIDTH-1:0] di_i,
  input  logic [WIDTH-1:0] rd_word_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_vld_o
);

  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] stg_data;
  logic             stg_vld;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q;

  // Written lanes take the incoming data; untouched lanes keep the stored word.
  always_comb begin
    merged = rd_word_i;
    for (int k = 0; k < NL; k++) begin
      if (byp_i && wmask_i[k]) merged[k*LANE_W +: LANE_W] = di_i[k*LANE_W +: LANE_W];
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] s1_q;
    logic             v1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_q <= '0;
        v1_q <= 1'b0;
      end else begin
        v1_q <= re_i;
        if (re_i) s1_q <= merged;
      end
    end

    assign stg_data = s1_q;
    assign stg_vld  = v1_q;
  end else begin : g_lat1
    assign stg_data = merged;
    assign stg_vld  = re_i;
  end

  assign dout_d = stg_vld ? stg_data : dout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= stg_vld;
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;

endmodule

// File: rtl/nv_ram_rws_param.sv
// Parametrised 1-read/1-write synchronous RAM with lane write masking and read valid.
// NV_RAM_RWS_INIT_CLR_EN adds a post-reset sequencer that zeroes the whole array.
module nv_ram_rws_param
  import nv_ram_rws_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 768,
  parameter int LANE_W = 32,
  parameter int RD_LAT = 1,
  parameter int AW     = $clog2(DEPTH),
  parameter int NL     = lane_count(WIDTH, LANE_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [NL-1:0]    wmask,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             init_busy,
  input  logic [31:0]      pwrbus_ram_pd
);

  if (!params_ok(DEPTH, WIDTH, LANE_W, RD_LAT)) begin : g_param_err
    $error("nv_ram_rws_param: illegal DEPTH/WIDTH/LANE_W/RD_LAT combination");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             re_eff, we_eff, ra_ok, wa_ok, byp;
  logic [WIDTH-1:0] rd_word;
  logic             unused_pwr;

`ifdef NV_RAM_RWS_INIT_CLR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE already clears entry 0, so the sweep takes exactly DEPTH cycles after rst.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_CLR;
        cnt_d   = cnt_q + 1'b1;
      end
      ST_CLR: begin
        if (cnt_q == LAST_ADDR) state_d = ST_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_DONE);
    clr_we   = busy;
    clr_addr = cnt_q;
  end
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign init_busy  = busy;
  assign unused_pwr = ^pwrbus_ram_pd;

  assign re_eff  = re & ~busy;
  assign we_eff  = we & ~busy;
  assign ra_ok   = 32'(ra) < DEPTH;
  assign wa_ok   = 32'(wa) < DEPTH;
  assign byp     = re_eff & we_eff & wa_ok & (ra == wa);
  assign rd_word = ra_ok ? mem_q[ra] : '0;

  // Array is never reset; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[clr_addr] <= '0;
      end else if (we_eff && wa_ok) begin
        for (int k = 0; k < NL; k++) begin
          if (wmask[k]) mem_q[wa][k*LANE_W +: LANE_W] <= di[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  nv_ram_rws_rd_pipe #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W),
    .RD_LAT (RD_LAT),
    .NL     (NL)
  ) u_rd_pipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .re_i       (re_eff),
    .byp_i      (byp),
    .wmask_i    (wmask),
    .di_i       (di),
    .rd_word_i  (rd_word),
    .dout_o     (dout),
    .dout_vld_o (dout_vld)
  );

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Bench for nv_ram_rws_param: a DEPTH=24/RD_LAT=1 and a DEPTH=32/RD_LAT=2 instance
// share all inputs and are scored against an array-level reference model.
`timescale 1ns/1ps
module tb_nv_ram_rws_param;

  localparam int W  = 128;
  localparam int LW = 32;
  localparam int NL = 4;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          re, we;
  logic [AW-1:0] ra, wa;
  logic [NL-1:0] wmask;
  logic [W-1:0]  di;
  logic [31:0]   pwr;
  logic [W-1:0]  dout0, dout1;
  logic          vld0, vld1, busy0, busy1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: index 0 is the DEPTH=24 instance, index 1 the DEPTH=32 one
  logic [W-1:0] ref_mem [2][32];
  logic [W-1:0] exp_dout [2];
  logic         exp_vld [2];
  logic [W:0]   exp_q [$];

  nv_ram_rws_param #(.DEPTH(24), .WIDTH(W), .LANE_W(LW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .re(re), .ra(ra), .we(we), .wa(wa), .wmask(wmask),
    .di(di), .dout(dout0), .dout_vld(vld0), .init_busy(busy0), .pwrbus_ram_pd(pwr)
  );

  nv_ram_rws_param #(.DEPTH(32), .WIDTH(W), .LANE_W(LW), .RD_LAT(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .re(re), .ra(ra), .we(we), .wa(wa), .wmask(wmask),
    .di(di), .dout(dout1), .dout_vld(vld1), .init_busy(busy1), .pwrbus_ram_pd(pwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dep_of(input int u);
    return (u == 0) ? 24 : 32;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_model_outputs();
    exp_dout[0] = '0; exp_dout[1] = '0;
    exp_vld[0]  = 1'b0; exp_vld[1] = 1'b0;
    exp_q.delete();
  endtask

  task automatic zero_model_mem();
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 32; a++) ref_mem[u][a] = '0;
  endtask

  // One clock of traffic: drive, predict from the model, then score both instances.
  task automatic do_cycle(input logic r, input logic [AW-1:0] a_r, input logic w,
                          input logic [AW-1:0] a_w, input logic [NL-1:0] m,
                          input logic [W-1:0] d);
    logic [W-1:0] rd [2];
    logic [W:0]   e;
    re = r; ra = a_r; we = w; wa = a_w; wmask = m; di = d;
    for (int u = 0; u < 2; u++) begin
      rd[u] = '0;
      if (int'(a_r) < dep_of(u)) begin
        rd[u] = ref_mem[u][a_r];
        if (w && (a_w == a_r))
          for (int k = 0; k < NL; k++)
            if (m[k]) rd[u][k*LW +: LW] = d[k*LW +: LW];
      end
      if (w && int'(a_w) < dep_of(u))
        for (int k = 0; k < NL; k++)
          if (m[k]) ref_mem[u][a_w][k*LW +: LW] = d[k*LW +: LW];
    end
    @(posedge clk);
    exp_vld[0] = r;
    if (r) exp_dout[0] = rd[0];
    exp_q.push_back({r, rd[1]});
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      exp_vld[1] = e[W];
      if (e[W]) exp_dout[1] = e[W-1:0];
    end else begin
      exp_vld[1] = 1'b0;
    end
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    check_eq("vld_l1", W'(vld0), W'(exp_vld[0]));
    check_eq("dout_l1", dout0, exp_dout[0]);
    check_eq("vld_l2", W'(vld1), W'(exp_vld[1]));
    check_eq("dout_l2", dout1, exp_dout[1]);
    check_eq("busy_idle", W'(busy0 | busy1), '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a_r, a_w;
    logic          busy_exp;
`ifdef NV_RAM_RWS_INIT_CLR_EN
    busy_exp = 1'b1;
`else
    busy_exp = 1'b0;
`endif
    rst = 1'b1; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wmask = '0; di = '0;
    pwr = 32'h0;
    zero_model_mem();
    clear_model_outputs();
    repeat (3) @(negedge clk);
    check_eq("rst_dout_l1", dout0, '0);
    check_eq("rst_vld_l1", W'(vld0), '0);
    check_eq("rst_dout_l2", dout1, '0);
    check_eq("rst_vld_l2", W'(vld1), '0);
    check_eq("rst_busy", W'(busy0 & busy1), W'(busy_exp));
    rst = 1'b0;

`ifdef NV_RAM_RWS_INIT_CLR_EN
    for (int p = 1; p <= 10; p++) begin
      @(posedge clk); @(negedge clk);
      check_eq("clr_busy_early", W'(busy0 & busy1), W'(1'b1));
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int p = 1; p <= 34; p++) begin
      re = (p == 10); we = (p == 10); ra = '0; wa = '0; wmask = '1; di = rand_word();
      @(posedge clk); @(negedge clk);
      re = 1'b0; we = 1'b0;
      check_eq("clr_busy_l1", W'(busy0), W'(p < 24));
      check_eq("clr_busy_l2", W'(busy1), W'(p < 32));
      check_eq("clr_vld", W'(vld0 | vld1), '0);
    end
    check_eq("clr_dout", dout0 | dout1, '0);
    zero_model_mem();
    for (int a = 0; a < 32; a++) do_cycle(1'b1, AW'(a), 1'b0, '0, '0, '0);
    idle(2);
`else
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      check_eq("busy_off", W'(busy0 | busy1), '0);
    end
`endif

    for (int a = 0; a < 32; a++) do_cycle(1'b0, '0, 1'b1, AW'(a), '1, rand_word());

    // basic full-word write then read
    do_cycle(1'b0, '0, 1'b1, 5'd5, '1, {4{32'hA5A5A5A5}});
    do_cycle(1'b1, 5'd5, 1'b0, '0, '0, '0);
    check_eq("basic_l1", dout0, {4{32'hA5A5A5A5}});
    check_eq("basic_vld", W'(vld0), W'(1'b1));
    idle(1);
    check_eq("basic_l2", dout1, {4{32'hA5A5A5A5}});
    check_eq("basic_vld_drop", W'(vld0), '0);

    // lane-masked write
    do_cycle(1'b0, '0, 1'b1, 5'd3, '1, {4{32'h11111111}});
    do_cycle(1'b0, '0, 1'b1, 5'd3, 4'b0101, {4{32'h22222222}});
    do_cycle(1'b1, 5'd3, 1'b0, '0, '0, '0);
    check_eq("masked_l1", dout0, {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222});

    // read-during-write lane merge
    do_cycle(1'b0, '0, 1'b1, 5'd7, '1, {4{32'hFFFFFFFF}});
    do_cycle(1'b1, 5'd7, 1'b1, 5'd7, 4'b0010, '0);
    check_eq("bypass_l1", dout0, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF});
    do_cycle(1'b1, 5'd7, 1'b0, '0, '0, '0);
    check_eq("bypass_reread", dout0, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF});
    check_eq("bypass_l2", dout1, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF});

    // back-to-back reads, then hold
    do_cycle(1'b1, 5'd0, 1'b0, '0, '0, '0);
    do_cycle(1'b1, 5'd1, 1'b0, '0, '0, '0);
    do_cycle(1'b1, 5'd2, 1'b0, '0, '0, '0);
    idle(3);

    // out-of-range access on the 24-entry instance
    do_cycle(1'b0, '0, 1'b1, 5'd30, '1, rand_word());
    do_cycle(1'b1, 5'd30, 1'b0, '0, '0, '0);
    check_eq("oor_l1", dout0, '0);
    check_eq("oor_vld", W'(vld0), W'(1'b1));
    do_cycle(1'b1, 5'd0, 1'b0, '0, '0, '0);

    // write one cycle after a read must not disturb the in-flight read
    do_cycle(1'b1, 5'd9, 1'b0, '0, '0, '0);
    do_cycle(1'b0, '0, 1'b1, 5'd9, '1, rand_word());
    idle(2);

    for (int i = 0; i < 400; i++) begin
      a_r = AW'($urandom_range(0, 31));
      a_w = ($urandom_range(0, 3) == 0) ? a_r : AW'($urandom_range(0, 31));
      do_cycle(1'b1 & 1'($urandom_range(0, 1)), a_r, 1'($urandom_range(0, 1)), a_w,
               NL'($urandom()), rand_word());
    end
    idle(2);

    // mid-run reset with a coincident write that must be dropped
    rst = 1'b1; we = 1'b1; wa = 5'd2; wmask = '1; di = rand_word(); re = 1'b0;
    clear_model_outputs();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; we = 1'b0;
    check_eq("rst2_dout", dout0 | dout1, '0);
    check_eq("rst2_vld", W'(vld0 | vld1), '0);
    check_eq("rst2_busy", W'(busy0 & busy1), W'(busy_exp));
`ifdef NV_RAM_RWS_INIT_CLR_EN
    for (int t = 0; t < 100 && (busy0 || busy1); t++) @(negedge clk);
    check_eq("clr_timeout", W'(busy0 | busy1), '0);
    zero_model_mem();
`endif
    do_cycle(1'b1, 5'd2, 1'b0, '0, '0, '0);
    do_cycle(1'b1, 5'd3, 1'b0, '0, '0, '0);
    do_cycle(1'b1, 5'd7, 1'b0, '0, '0, '0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
